// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard unit: forwarding, load-use/branch/memory stalls, timeout FSM
// Optional HAZARD_FWD_EN: operand forwarding; without it, any pending register write to a Decode source stalls.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  RA1D,
    input  logic [3:0]  RA2D,
    input  logic [3:0]  RA1E,
    input  logic [3:0]  RA2E,
    input  logic [3:0]  WriteAddrE,
    input  logic [3:0]  WriteAddrM,
    input  logic [3:0]  WriteAddrW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        BranchTakenE,
    input  logic        MemReqM,
    input  logic        MemReady,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        MemErr,
    output logic [15:0] StallCnt
);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} memState_t;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_TIMEOUT - 1);

    memState_t  state, nextState;
    logic [3:0] waitCnt, nextWaitCnt;
    logic       memStall;
    logic       loadUse;
    logic       regHazard;
    logic [1:0] fwdA, fwdB;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Stall is raised combinationally so the very first missed cycle already holds the pipe.
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        memStall    = 1'b0;
        case (state)
            IDLE: begin
                if (MemReqM && !MemReady) begin
                    nextState   = WAIT;
                    nextWaitCnt = 4'd0;
                    memStall    = 1'b1;
                end
            end
            WAIT: begin
                if (MemReady) begin
                    nextState = IDLE;
                end else begin
                    memStall = 1'b1;
                    if (waitCnt == LAST_WAIT) begin
                        nextState = ERR;
                    end else begin
                        nextWaitCnt = waitCnt + 4'd1;
                    end
                end
            end
            ERR: begin
                memStall = 1'b1;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign loadUse = LoadE && ((WriteAddrE == RA1D) || (WriteAddrE == RA2D));

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwdSel(input logic [3:0] src);
        if (RegWriteM && (WriteAddrM == src) && (src != 4'hF)) begin
            return 2'b10;
        end else if (RegWriteW && (WriteAddrW == src) && (src != 4'hF)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign fwdA      = fwdSel(RA1E);
    assign fwdB      = fwdSel(RA2E);
    assign regHazard = 1'b0;

    logic unusedSink;
    assign unusedSink = RegWriteE;
`else
    function automatic logic depHit(input logic [3:0] src);
        return (src != 4'hF) &&
               ((RegWriteE && (WriteAddrE == src)) ||
                (RegWriteM && (WriteAddrM == src)) ||
                (RegWriteW && (WriteAddrW == src)));
    endfunction

    assign fwdA      = 2'b00;
    assign fwdB      = 2'b00;
    assign regHazard = depHit(RA1D) || depHit(RA2D);

    logic unusedSink;
    assign unusedSink = ^{RA1E, RA2E};
`endif

    // Reset gates every combinational output so nothing leaks out while reset is held.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset) begin
            ForwardAE = fwdA;
            ForwardBE = fwdB;
            if (memStall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (BranchTakenE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (loadUse || regHazard) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    assign MemErr = (state == ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCnt <= 16'd0;
        end else if (StallF && (StallCnt != 16'hFFFF)) begin
            StallCnt <= StallCnt + 16'd1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum memory wait cycles before error, range 1..15.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 RA1D, RA2D  input  4 each  source register addresses in Decode.
REQ-005 RA1E, RA2E  input  4 each  source register addresses in Execute.
REQ-006 WriteAddrE, WriteAddrM, WriteAddrW  input  4 each  destination addresses per stage.
REQ-007 RegWriteE, RegWriteM, RegWriteW  input  1 each  register-write enables per stage.
REQ-008 LoadE  input  1  Execute-stage instruction is a load.
REQ-009 BranchTakenE  input  1  branch/PC write resolved taken in Execute.
REQ-010 MemReqM  input  1  Memory stage issues a data access, load or store.
REQ-011 MemReady  input  1  data memory completes the access this cycle.
REQ-012 ForwardAE, ForwardBE  output  2 each  operand select: 00 register file, 01 WB result, 10 MEM result.
REQ-013 StallF, StallD, StallE, StallM  output  1 each  hold the corresponding pipeline register.
REQ-014 FlushD, FlushE, FlushW  output  1 each  load a bubble into the corresponding pipeline register.
REQ-015 MemErr  output  1  sticky memory-timeout error.
REQ-016 StallCnt  output  16  saturating count of cycles with StallF high.

Function
REQ-017 Memory FSM states SHALL be IDLE, WAIT and ERR.
REQ-018 IDLE: MemReqM=1 and MemReady=0 -> WAIT, wait counter cleared; otherwise remain in IDLE.
REQ-019 WAIT: MemReady=1 -> IDLE; counter reaching MEM_TIMEOUT with MemReady=0 -> ERR; otherwise counter increments.
REQ-020 ERR SHALL be terminal until reset; MemErr=1 in ERR.
REQ-021 Memory stall is combinational: (IDLE and MemReqM and !MemReady) or WAIT or ERR -> StallF, StallD, StallE and StallM high, FlushW high.
REQ-022 The cycle MemReady=1 in WAIT SHALL deassert all memory stalls in that same cycle.
REQ-023 Load-use: LoadE and WriteAddrE equal to RA1D or RA2D -> StallF, StallD and FlushE high for that cycle.
REQ-024 Branch: BranchTakenE=1 -> FlushD and FlushE high.
REQ-025 Priority SHALL be memory stall, then branch flush, then load-use; a lower-priority action SHALL be suppressed while a higher one is active.
REQ-026 BranchTakenE during a memory stall SHALL take effect on the first unstalled cycle, because StallE holds the Execute stage.
REQ-027 Forwarding, per operand: 10 if RegWriteM, WriteAddrM equals the source, and the source is not 4'hF.
REQ-028 Otherwise 01 if RegWriteW, WriteAddrW equals the source, and the source is not 4'hF.
REQ-029 Otherwise 00; the MEM match SHALL win when MEM and WB both match.
REQ-030 StallCnt SHALL increment on each clock with StallF=1 and hold at 16'hFFFF.

Reset
REQ-031 reset low SHALL asynchronously force: FSM to IDLE, wait counter to 0, MemErr 0, StallCnt 0.
REQ-032 During reset, all stall, flush and forward outputs SHALL be 0.
REQ-033 Reset asserted mid-WAIT or in ERR SHALL abort to IDLE with no residual stall after release.

Configuration
REQ-034 Macro HAZARD_FWD_EN defined: forwarding per REQ-027 to REQ-029.
REQ-035 HAZARD_FWD_EN undefined: ForwardAE and ForwardBE SHALL be tied to 00.
REQ-036 HAZARD_FWD_EN undefined: any RegWriteE, RegWriteM or RegWriteW destination matching RA1D or RA2D (excluding 4'hF) SHALL assert StallF, StallD and FlushE, at load-use priority.

Verification
REQ-037 RegWriteM=1, WriteAddrM=3, RA1E=3, with RegWriteW=1 and WriteAddrW=3 -> ForwardAE=10 (macro defined).
REQ-038 LoadE=1, WriteAddrE=5, RA2D=5 -> StallF=StallD=FlushE=1 for exactly one cycle.
REQ-039 MemReqM=1, MemReady low for 3 cycles then high -> StallM and FlushW high for 3 cycles, FSM ends in IDLE, StallCnt=3.
REQ-040 MemReqM=1, MemReady held low, MEM_TIMEOUT=4 -> ERR entered after 4 WAIT cycles, MemErr=1, stalls persist until reset.
REQ-041 BranchTakenE=1 while in WAIT -> FlushD and FlushE stay 0 until MemReady=1, then both high.
REQ-042 reset low mid-WAIT -> all outputs 0 immediately without a clock edge, and StallCnt=0.
